// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and LSB requests onto a byte-wide RAM/IO bus.
// Optional IO back-pressure on stores is enabled by defining MEM_CTRL_IO_STALL_EN.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              misbranch_flag,
  input  logic              if_start,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_finish,
  output logic [DATA_W-1:0] if_inst,
  input  logic              lsb_start,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_finish,
  output logic [DATA_W-1:0] lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic [1:0]        dbg_state
);

  // Client handshake: *_start is a one-cycle request pulse that is latched until granted;
  // *_finish is a one-cycle completion pulse. Clients are never back-pressured.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  state_t            state_q, state_n;
  logic [2:0]        cnt_q, cnt_n;
  logic [2:0]        len_q, len_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [DATA_W-1:0] wbuf_q, wbuf_n;
  logic [DATA_W-1:0] rbuf_q, rbuf_n;

  logic              if_pend_q, if_pend_n;
  logic [ADDR_W-1:0] if_pc_q, if_pc_n;
  logic              lsb_pend_q, lsb_pend_n;
  logic              lsb_wr_q, lsb_wr_n;
  logic [1:0]        lsb_size_q, lsb_size_n;
  logic [ADDR_W-1:0] lsb_addr_q, lsb_addr_n;
  logic [DATA_W-1:0] lsb_wdata_q, lsb_wdata_n;

  logic [ADDR_W-1:0] mem_a_q, mem_a_n;
  logic [7:0]        mem_dout_q, mem_dout_n;
  logic              mem_wr_q, mem_wr_n;
  logic              if_finish_q, if_finish_n;
  logic [DATA_W-1:0] if_inst_q, if_inst_n;
  logic              lsb_finish_q, lsb_finish_n;
  logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_n;

  logic              store_blocked;
  logic [2:0]        cnt_inc;
  logic [2:0]        cnt_dec;
  logic              reading;

  assign cnt_inc = cnt_q + 3'd1;
  assign cnt_dec = cnt_q - 3'd1;
  assign reading = (state_q == IFETCH) || (state_q == LOAD);

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    size_len = 3'd1;
      2'd1:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

`ifndef MEM_CTRL_IO_STALL_EN
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
`endif

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    len_n         = len_q;
    base_n        = base_q;
    wbuf_n        = wbuf_q;
    rbuf_n        = rbuf_q;
    if_pend_n     = if_pend_q;
    if_pc_n       = if_pc_q;
    lsb_pend_n    = lsb_pend_q;
    lsb_wr_n      = lsb_wr_q;
    lsb_size_n    = lsb_size_q;
    lsb_addr_n    = lsb_addr_q;
    lsb_wdata_n   = lsb_wdata_q;
    mem_a_n       = mem_a_q;
    mem_dout_n    = mem_dout_q;
    mem_wr_n      = mem_wr_q;
    if_finish_n   = if_finish_q;
    if_inst_n     = if_inst_q;
    lsb_finish_n  = lsb_finish_q;
    lsb_rdata_n   = lsb_rdata_q;
    store_blocked = 1'b0;

    if (rdy) begin
      mem_wr_n     = 1'b0;
      if_finish_n  = 1'b0;
      lsb_finish_n = 1'b0;

      // Stores are already committed, so a flush only drops speculative reads and new pulses.
      if (misbranch_flag) begin
        if_pend_n = 1'b0;
        if (!lsb_wr_q) lsb_pend_n = 1'b0;
      end else begin
        if (if_start) begin
          if_pend_n = 1'b1;
          if_pc_n   = if_pc;
        end
        if (lsb_start) begin
          lsb_pend_n  = 1'b1;
          lsb_wr_n    = lsb_wr;
          lsb_size_n  = lsb_size;
          lsb_addr_n  = lsb_addr;
          lsb_wdata_n = lsb_wdata;
        end
      end

`ifdef MEM_CTRL_IO_STALL_EN
      store_blocked = lsb_wr_n && (lsb_addr_n[17:16] == 2'b11) && io_buffer_full;
`endif

      case (state_q)
        IDLE: begin
          if (lsb_pend_n && !store_blocked) begin
            lsb_pend_n = 1'b0;
            base_n     = lsb_addr_n;
            len_n      = size_len(lsb_size_n);
            mem_a_n    = lsb_addr_n;
            if (lsb_wr_n) begin
              mem_wr_n   = 1'b1;
              mem_dout_n = lsb_wdata_n[7:0];
              wbuf_n     = lsb_wdata_n >> 8;
              if (size_len(lsb_size_n) == 3'd1) begin
                lsb_finish_n = 1'b1;
              end else begin
                state_n = STORE;
                cnt_n   = 3'd1;
              end
            end else begin
              state_n = LOAD;
              cnt_n   = 3'd0;
              rbuf_n  = '0;
            end
          end else if (if_pend_n) begin
            if_pend_n = 1'b0;
            base_n    = if_pc_n;
            len_n     = 3'd4;
            mem_a_n   = if_pc_n;
            state_n   = IFETCH;
            cnt_n     = 3'd0;
            rbuf_n    = '0;
          end
        end

        IFETCH, LOAD: begin
          if (misbranch_flag) begin
            state_n = IDLE;
          end else begin
            // Byte cnt-1 arrives on this edge; address cnt+1 is issued ahead of it.
            if (cnt_q != 3'd0) begin
              rbuf_n = rbuf_q | (DATA_W'(mem_din) << {cnt_dec, 3'b000});
            end
            if (cnt_q == len_q) begin
              state_n = IDLE;
              if (state_q == IFETCH) begin
                if_finish_n = 1'b1;
                if_inst_n   = rbuf_n;
              end else begin
                lsb_finish_n = 1'b1;
                lsb_rdata_n  = rbuf_n;
              end
            end else begin
              if (cnt_inc < len_q) mem_a_n = base_q + ADDR_W'(cnt_inc);
              cnt_n = cnt_inc;
            end
          end
        end

        STORE: begin
          mem_wr_n   = 1'b1;
          mem_a_n    = base_q + ADDR_W'(cnt_q);
          mem_dout_n = wbuf_q[7:0];
          wbuf_n     = wbuf_q >> 8;
          if (cnt_q == len_q - 3'd1) begin
            lsb_finish_n = 1'b1;
            state_n      = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
      if_pend_q    <= 1'b0;
      if_pc_q      <= '0;
      lsb_pend_q   <= 1'b0;
      lsb_wr_q     <= 1'b0;
      lsb_size_q   <= '0;
      lsb_addr_q   <= '0;
      lsb_wdata_q  <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_finish_q  <= 1'b0;
      if_inst_q    <= '0;
      lsb_finish_q <= 1'b0;
      lsb_rdata_q  <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      len_q        <= len_n;
      base_q       <= base_n;
      wbuf_q       <= wbuf_n;
      rbuf_q       <= rbuf_n;
      if_pend_q    <= if_pend_n;
      if_pc_q      <= if_pc_n;
      lsb_pend_q   <= lsb_pend_n;
      lsb_wr_q     <= lsb_wr_n;
      lsb_size_q   <= lsb_size_n;
      lsb_addr_q   <= lsb_addr_n;
      lsb_wdata_q  <= lsb_wdata_n;
      mem_a_q      <= mem_a_n;
      mem_dout_q   <= mem_dout_n;
      mem_wr_q     <= mem_wr_n;
      if_finish_q  <= if_finish_n;
      if_inst_q    <= if_inst_n;
      lsb_finish_q <= lsb_finish_n;
      lsb_rdata_q  <= lsb_rdata_n;
    end
  end

  // While frozen mid-read, point the RAM at the byte still owed so it is valid on resume.
  assign mem_a      = (!rdy && reading && cnt_q != 3'd0) ? base_q + ADDR_W'(cnt_dec) : mem_a_q;
  assign mem_wr     = mem_wr_q & rdy;
  assign mem_dout   = mem_dout_q;
  assign if_finish  = if_finish_q;
  assign if_inst    = if_inst_q;
  assign lsb_finish = lsb_finish_q;
  assign lsb_rdata  = lsb_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
// Covers fetch, store, contention, misbranch, IO stall (both macro settings) and rdy freeze.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        misbranch_flag;
  logic        if_start;
  logic [31:0] if_pc;
  logic        if_finish;
  logic [31:0] if_inst;
  logic        lsb_start;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_finish;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:262143];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
    .if_start(if_start), .if_pc(if_pc), .if_finish(if_finish), .if_inst(if_inst),
    .lsb_start(lsb_start), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_finish(lsb_finish), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // RAM: registered read of mem_a, write on strobe, small preload while in reset.
  always @(posedge clk) begin
    if (rst) begin
      ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
      ram[18'h00102] <= 8'h10; ram[18'h00103] <= 8'h00;
      ram[18'h00104] <= 8'h93; ram[18'h00105] <= 8'h00;
      ram[18'h00106] <= 8'h20; ram[18'h00107] <= 8'h00;
      ram[18'h00010] <= 8'h80;
      ram[18'h00200] <= 8'h11; ram[18'h00201] <= 8'h22;
      ram[18'h00202] <= 8'h33; ram[18'h00203] <= 8'h44;
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wd;
    logic        seen;

    rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0;
    if_start = 1'b0; if_pc = '0;
    lsb_start = 1'b0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    io_buffer_full = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_if_finish", 32'(if_finish), 32'd0);
    chk("rst_lsb_finish", 32'(lsb_finish), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick(); tick();

    // Fetch at 0x100
    if_start = 1'b1; if_pc = 32'h100;
    tick(); if_start = 1'b0;
    chk("fetch_a0", mem_a, 32'h100);
    chk("fetch_state", 32'(dbg_state), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("fetch_a%0d", k), mem_a, 32'h100 + 32'(k));
    end
    tick(); chk("fetch_early", 32'(if_finish), 32'd0);
    tick();
    chk("fetch_finish", 32'(if_finish), 32'd1);
    chk("fetch_inst", if_inst, 32'h00100513);
    chk("fetch_idle", 32'(dbg_state), 32'd0);
    tick();
    chk("fetch_pulse_end", 32'(if_finish), 32'd0);
    chk("fetch_inst_hold", if_inst, 32'h00100513);

    // Word store 0xDEADBEEF at 0x2000
    wd = 32'hDEADBEEF;
    lsb_start = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h2000; lsb_wdata = wd;
    tick(); lsb_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk($sformatf("store_wr%0d", k), 32'(mem_wr), 32'd1);
      chk($sformatf("store_a%0d", k), mem_a, 32'h2000 + 32'(k));
      chk($sformatf("store_d%0d", k), 32'(mem_dout), (wd >> (8 * k)) & 32'hFF);
      chk($sformatf("store_fin%0d", k), 32'(lsb_finish), (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("store_wr_end", 32'(mem_wr), 32'd0);
    chk("store_fin_end", 32'(lsb_finish), 32'd0);

    // Read the stored word back
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h2000;
    tick(); lsb_start = 1'b0;
    repeat (4) tick();
    chk("rdback_early", 32'(lsb_finish), 32'd0);
    tick();
    chk("rdback_fin", 32'(lsb_finish), 32'd1);
    chk("rdback_data", lsb_rdata, 32'hDEADBEEF);
    tick();

    // Contention: byte load at 0x10 beats fetch at 0x104
    if_start = 1'b1; if_pc = 32'h104;
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h10;
    tick(); if_start = 1'b0; lsb_start = 1'b0;
    chk("cont_a", mem_a, 32'h10);
    chk("cont_state", 32'(dbg_state), 32'd2);
    tick(); chk("cont_early", 32'(lsb_finish), 32'd0);
    tick();
    chk("cont_fin", 32'(lsb_finish), 32'd1);
    chk("cont_rdata", lsb_rdata, 32'h00000080);
    chk("cont_idle_a", mem_a, 32'h10);
    chk("cont_idle", 32'(dbg_state), 32'd0);
    tick();
    chk("cont_fetch_a", mem_a, 32'h104);
    chk("cont_fetch_state", 32'(dbg_state), 32'd1);
    repeat (4) tick();
    chk("cont_fetch_early", 32'(if_finish), 32'd0);
    tick();
    chk("cont_fetch_fin", 32'(if_finish), 32'd1);
    chk("cont_fetch_inst", if_inst, 32'h00200093);
    tick();

    // Half load at 0x100, zero-extended
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd1; lsb_addr = 32'h100;
    tick(); lsb_start = 1'b0;
    tick(); tick();
    chk("half_early", 32'(lsb_finish), 32'd0);
    tick();
    chk("half_fin", 32'(lsb_finish), 32'd1);
    chk("half_data", lsb_rdata, 32'h00000513);
    tick();

    // Misbranch during fetch
    if_start = 1'b1; if_pc = 32'h100;
    tick(); if_start = 1'b0;
    chk("flush_fetch_state", 32'(dbg_state), 32'd1);
    tick(); misbranch_flag = 1'b1;
    tick(); misbranch_flag = 1'b0;
    chk("flush_idle", 32'(dbg_state), 32'd0);
    seen = if_finish;
    repeat (6) begin
      tick();
      seen = seen | if_finish;
    end
    chk("flush_no_finish", 32'(seen), 32'd0);
    chk("flush_inst_hold", if_inst, 32'h00200093);

    // Misbranch during word store: store completes
    lsb_start = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h3000; lsb_wdata = 32'hCAFEF00D;
    tick(); lsb_start = 1'b0;
    tick(); misbranch_flag = 1'b1;
    tick(); misbranch_flag = 1'b0;
    chk("flush_st_wr", 32'(mem_wr), 32'd1);
    chk("flush_st_a", mem_a, 32'h3002);
    chk("flush_st_d", 32'(mem_dout), 32'hFE);
    chk("flush_st_state", 32'(dbg_state), 32'd3);
    tick();
    chk("flush_st_fin", 32'(lsb_finish), 32'd1);
    chk("flush_st_d3", 32'(mem_dout), 32'hCA);
    tick();
    chk("flush_st_fin_end", 32'(lsb_finish), 32'd0);

    // IO store to 0x30000 with the UART buffer full
    lsb_start = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h5A;
    io_buffer_full = 1'b1;
    tick(); lsb_start = 1'b0;
`ifdef MEM_CTRL_IO_STALL_EN
    seen = mem_wr;
    repeat (9) begin
      tick();
      seen = seen | mem_wr;
    end
    chk("io_stall_no_wr", 32'(seen), 32'd0);
    chk("io_stall_idle", 32'(dbg_state), 32'd0);
    io_buffer_full = 1'b0;
    tick();
`endif
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_a", mem_a, 32'h30000);
    chk("io_d", 32'(mem_dout), 32'h5A);
    chk("io_fin", 32'(lsb_finish), 32'd1);
`ifndef MEM_CTRL_IO_STALL_EN
    repeat (9) tick();
    io_buffer_full = 1'b0;
`endif
    tick();
    chk("io_wr_end", 32'(mem_wr), 32'd0);

    // rdy freeze for 3 cycles during a word load at 0x200
    lsb_start = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h200;
    tick(); lsb_start = 1'b0;
    tick(); rdy = 1'b0;
    tick();
    chk("frz_state", 32'(dbg_state), 32'd2);
    chk("frz_mem_wr", 32'(mem_wr), 32'd0);
    chk("frz_mem_a", mem_a, 32'h200);
    tick(); tick(); rdy = 1'b1;
    tick(); tick(); tick();
    chk("frz_early", 32'(lsb_finish), 32'd0);
    tick();
    chk("frz_fin", 32'(lsb_finish), 32'd1);
    chk("frz_data", lsb_rdata, 32'h44332211);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between the instruction fetcher, the load/store buffer (LSB) and the byte-wide RAM/IO port. Latches pulse requests from both clients, serialises each access into byte transfers on the RAM bus, and returns assembled words with a one-cycle done pulse. It honours misbranch flushes and the IO buffer-full back-pressure.

## Interface
- `ADDR_W`, 32, address width (`ADDR_TYPE`)
- `DATA_W`, 32, word width (`INST_TYPE`)
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global enable. Low freezes all state and forces `mem_wr` to 0.
- `misbranch_flag` in 1: ROB flush
- `if_start` in 1: fetch request pulse
- `if_pc` in 32: fetch address
- `if_finish` out 1: fetch done pulse
- `if_inst` out 32: fetched instruction
- `lsb_start` in 1: LSB request pulse
- `lsb_wr` in 1: 1 = store, 0 = load
- `lsb_size` in 2: access size; 0 = byte, 1 = half, 2 = word
- `lsb_addr` in 32: LSB access address
- `lsb_wdata` in 32: store data
- `lsb_finish` out 1: LSB done pulse
- `lsb_rdata` out 32: load data, zero-extended (the LSB sign-extends)
- `mem_din` in 8: RAM read byte
- `mem_dout` out 8: RAM write byte
- `mem_a` out 32: RAM address
- `mem_wr` out 1: RAM write strobe
- `io_buffer_full` in 1: UART buffer full

## Operation
- **States:** IDLE, IFETCH, LOAD, STORE.
- **Pending latches:**
  - `if_start` sets `if_pend` and captures `if_pc`.
  - `lsb_start` sets `lsb_pend` and captures addr, size, wr and wdata.
  - A latch is cleared when its access is granted.
  - A new pulse arriving while the same client is already pending overwrites the captured fields.
- **Grant (IDLE only):** LSB has fixed priority over fetch. Grant happens on the same edge the pulse is sampled if IDLE.
- **Byte count:** N = 4 for a fetch; N = 1 << `lsb_size` for the LSB. `lsb_size` = 3 is treated as 4 bytes.
- **Byte order:** little-endian. Byte k goes to or comes from address addr+k, with 32-bit wrap-around on addr+k. It occupies data bits [8k+7:8k].
- **Reads:** `mem_a` = addr+k for k = 0..N-1 on successive cycles, `mem_wr` = 0. RAM returns the byte one cycle after sampling the address.
- **Stores:** `mem_a` = addr+k, `mem_dout` = byte k, `mem_wr` = 1 for exactly N cycles.
- **Completion:** the done pulse (`if_finish` or `lsb_finish`) is high for exactly one cycle. Result data stays stable until the next completion of the same client.
- **Misbranch**, when asserted in a cycle:
  - An IFETCH or LOAD in progress aborts to IDLE with no done pulse.
  - `if_pend` and a pending load are cleared.
  - A STORE in progress and a pending store are kept and complete normally, since stores are ROB-committed.
  - A request pulse arriving in the same cycle as the flush is dropped.
- **Reset values:** all outputs 0, state IDLE, both pend latches 0.

## Timing
- Request pulse sampled at edge E0 while IDLE:
  - `mem_a` = addr from E0.
  - Byte k is sampled at E(k+2).
  - The done pulse is high for the cycle after E(N+1). Fetch latency is therefore 5 cycles, byte load 2, word load 5.
- Store sampled at E0: strobes run for the N cycles after E0..E(N-1), and `lsb_finish` is high for the cycle after E(N-1).
- The FSM returns to IDLE on the completion edge.
  - A pending request is granted on the next edge, giving one idle bus cycle between accesses (`mem_wr` = 0, `mem_a` holds its last value).
- Simultaneous `if_start` and `lsb_start` in IDLE: the LSB is served first and the fetch stays pending.
- `rdy` low mid-access: all counters and the FSM freeze and `mem_wr` = 0. The access resumes unchanged when `rdy` returns, with the byte being sampled re-read from `mem_a`.
- Reset mid-access: the FSM goes to IDLE at the next edge, the transfer is abandoned and no done pulse is issued.

## Configuration
- **`MEM_CTRL_IO_STALL_EN` defined:** a STORE whose address has bits [17:16] == 2'b11 (IO space 0x30000+) does not start while `io_buffer_full` = 1.
  - The FSM stays IDLE with the store pending; fetches may be granted meanwhile.
  - The store starts on the first IDLE edge where `io_buffer_full` = 0.
  - An IO store already in progress is not interrupted.
- **Not defined:** `io_buffer_full` is ignored and IO stores issue immediately.

## Test plan
- **Fetch:** `if_start`, `if_pc` = 0x100; RAM bytes 0x13,0x05,0x10,0x00 → `mem_a` 0x100..0x103, then `if_finish` 5 cycles after the request with `if_inst` = 0x00100513.
- **Word store:** `lsb_start`, store word 0xDEADBEEF at 0x2000 → 4 cycles of `mem_wr` = 1 writing bytes EF,BE,AD,DE to 0x2000..0x2003, then `lsb_finish`.
- **Contention:** `if_start` and a byte load at 0x10 (RAM holds 0x80) in the same cycle → load served first with `lsb_rdata` = 0x00000080 after 2 cycles; fetch starts on the following edge.
- **Misbranch during fetch:** flush 2 cycles into a fetch → no `if_finish`, FSM IDLE next cycle. Repeat the flush during a word store → the store completes and `lsb_finish` fires.
- **IO stall (macro on):** byte store to 0x30000 with `io_buffer_full` = 1 for 10 cycles → `mem_wr` stays 0; the write fires on the cycle after `io_buffer_full` drops. With the macro off, the write fires immediately.
- **`rdy` freeze:** drop `rdy` for 3 cycles mid word-load → completion delayed by exactly 3 cycles and data intact.
